// File: rtl/multicycle_control.sv
// multicycle_control: LEGv8 multi-cycle control FSM with memory handshake, retire counter and sticky faults
module multicycle_control #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [10:0]      op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             reg2loc,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_source,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal,
  output logic             mem_fault
);
  localparam int WW = $clog2(TIMEOUT + 2);
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_ADDR = 4'd2, S_MEMRD = 4'd3,
                         S_LDWB = 4'd4, S_MEMWR = 4'd5, S_REXEC = 4'd6, S_RWB = 4'd7,
                         S_CBZ = 4'd8, S_BR = 4'd9, S_HALT = 4'd15;
  localparam logic [10:0] OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000,
                          OP_ADD = 11'b10001011000, OP_SUB = 11'b11001011000,
                          OP_AND = 11'b10001010000, OP_ORR = 11'b10101010000;
  logic [3:0]       r_state, w_next, w_st;
  logic [WW-1:0]    r_wait;
  logic [CNT_W-1:0] r_cnt;
  logic             r_illegal, r_fault;
  logic             w_wait_st, w_tout, w_rfmt, w_cbz;
  assign w_wait_st = r_state == S_FETCH || r_state == S_MEMRD || r_state == S_MEMWR;
  assign w_tout = TIMEOUT != 0 && w_wait_st && !mem_ready && r_wait == WW'(TIMEOUT - 1);
  assign w_rfmt = op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR;
  assign w_cbz = op[10:3] == 8'b10110100;
  assign w_st = rst_n ? r_state : S_FETCH;
  assign state = w_st;
  assign instr_count = r_cnt;
  assign illegal = r_illegal;
  assign mem_fault = r_fault;
  // state register; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else r_state <= w_next;
  end
  // next-state: sequencing, opcode dispatch and memory-wait timeout
  always_comb begin
    w_next = S_HALT;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: w_next = (op == OP_LDUR || op == OP_STUR) ? S_ADDR :
                         w_rfmt ? S_REXEC : w_cbz ? S_CBZ :
                         op[10:5] == 6'b000101 ? S_BR : S_HALT;
      S_ADDR:   w_next = op == OP_STUR ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = mem_ready ? S_LDWB : S_MEMRD;
      S_LDWB:   w_next = S_FETCH;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_REXEC:  w_next = S_RWB;
      S_RWB:    w_next = S_FETCH;
      S_CBZ:    w_next = S_FETCH;
      S_BR:     w_next = S_FETCH;
      default:  w_next = S_HALT;
    endcase
    if (w_tout) w_next = S_HALT;
  end
  // datapath controls decoded from state; strobes are suppressed during reset
  always_comb begin
    {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg, reg2loc, alu_src_a, pc_source} = '0;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    case (w_st)
      S_FETCH:  begin mem_read = 1'b1; alu_src_b = 2'b01; ir_write = mem_ready; pc_write = mem_ready; end
      S_DECODE: begin alu_src_b = 2'b11; reg2loc = op == OP_STUR || w_cbz; end
      S_ADDR:   begin alu_src_a = 1'b1; alu_src_b = 2'b10; reg2loc = op == OP_STUR; end
      S_MEMRD:  begin i_or_d = 1'b1; mem_read = 1'b1; end
      S_LDWB:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      S_MEMWR:  begin i_or_d = 1'b1; mem_write = 1'b1; reg2loc = 1'b1; end
      S_REXEC:  begin alu_src_a = 1'b1; alu_op = 2'b10; end
      S_RWB:    reg_write = 1'b1;
      S_CBZ:    begin reg2loc = 1'b1; alu_op = 2'b01; pc_source = 1'b1; pc_write = zero; end
      S_BR:     begin pc_write = 1'b1; pc_source = 1'b1; end
      default:  ;
    endcase
    if (!rst_n) {pc_write, ir_write, mem_read, mem_write, reg_write} = '0;
  end
  // wait counter, retire counter and sticky fault flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait <= '0;
      r_cnt <= '0;
      r_illegal <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_wait <= (w_wait_st && !mem_ready && !w_tout) ? r_wait + 1'b1 : '0;
      if (w_next == S_FETCH && r_state != S_FETCH) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_DECODE && w_next == S_HALT) r_illegal <= 1'b1;
      if (w_tout) r_fault <= 1'b1;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-level reference model driving randomized ready/opcode traffic
module tb_multicycle_control;
  localparam int TO = 4;
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, ADDR = 4'd2, MEMRD = 4'd3, LDWB = 4'd4,
                         MEMWR = 4'd5, REXEC = 4'd6, RWB = 4'd7, CBZ = 4'd8, BR = 4'd9, HALT = 4'd15;
  localparam logic [10:0] LDUR_OP = 11'b11111000010, STUR_OP = 11'b11111000000;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [10:0] op = '0;
  logic pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg, reg2loc, alu_src_a, pc_source;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state;
  logic [31:0] instr_count;
  logic illegal, mem_fault;
  int checks = 0, errors = 0;
  logic [31:0] cnt_m = '0;
  logic ill_m = 1'b0, flt_m = 1'b0;
  multicycle_control #(.CNT_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg2loc(reg2loc),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .instr_count(instr_count), .illegal(illegal), .mem_fault(mem_fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int cls(input logic [10:0] o);
    if (o == LDUR_OP) return 1;
    if (o == STUR_OP) return 2;
    if (o == 11'b10001011000 || o == 11'b11001011000 || o == 11'b10001010000 || o == 11'b10101010000) return 3;
    if (o[10:3] == 8'b10110100) return 4;
    if (o[10:5] == 6'b000101) return 5;
    return 0;
  endfunction
  function automatic logic [17:0] exp_vec(input logic [3:0] s, input logic rdy, input logic z, input logic [10:0] o);
    logic pw, iw, iod, mr, mw, rw, m2r, r2l, asa, ps;
    logic [1:0] asb, aop;
    {pw, iw, iod, mr, mw, rw, m2r, r2l, asa, ps} = '0;
    asb = 2'b00;
    aop = 2'b00;
    case (s)
      FETCH:  begin mr = 1'b1; asb = 2'b01; pw = rdy; iw = rdy; end
      DECODE: begin asb = 2'b11; r2l = cls(o) == 2 || cls(o) == 4; end
      ADDR:   begin asa = 1'b1; asb = 2'b10; r2l = cls(o) == 2; end
      MEMRD:  begin iod = 1'b1; mr = 1'b1; end
      LDWB:   begin rw = 1'b1; m2r = 1'b1; end
      MEMWR:  begin iod = 1'b1; mw = 1'b1; r2l = 1'b1; end
      REXEC:  begin asa = 1'b1; aop = 2'b10; end
      RWB:    rw = 1'b1;
      CBZ:    begin r2l = 1'b1; aop = 2'b01; ps = 1'b1; pw = z; end
      BR:     begin pw = 1'b1; ps = 1'b1; end
      default: ;
    endcase
    return {s, pw, iw, iod, mr, mw, rw, m2r, r2l, asa, asb, aop, ps};
  endfunction
  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic step(input logic [3:0] s, input logic rdy);
    mem_ready = rdy;
    #1;
    chk($sformatf("outputs_in_state_%0d", s),
        {14'b0, state, pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg,
         reg2loc, alu_src_a, alu_src_b, alu_op, pc_source},
        {14'b0, exp_vec(s, rdy, zero, op)});
    chk("instr_count", instr_count, cnt_m);
    chk("illegal", {31'b0, illegal}, {31'b0, ill_m});
    chk("mem_fault", {31'b0, mem_fault}, {31'b0, flt_m});
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = rnd();
    #1;
    chk("strobes_in_reset", {27'b0, pc_write, ir_write, mem_read, mem_write, reg_write}, 32'd0);
    chk("state_in_reset", {28'b0, state}, {28'b0, FETCH});
    @(negedge clk);
    rst_n = 1'b1;
    cnt_m = '0;
    ill_m = 1'b0;
    flt_m = 1'b0;
  endtask
  task automatic halt_and_reset();
    repeat (3) step(HALT, rnd());
    do_reset();
  endtask
  task automatic wait_phase(input logic [3:0] s, input int n, output bit ok);
    for (int i = 0; i < n && i < TO; i++) step(s, 1'b0);
    if (n >= TO) begin
      flt_m = 1'b1;
      halt_and_reset();
      ok = 1'b0;
    end else begin
      step(s, 1'b1);
      ok = 1'b1;
    end
  endtask
  task automatic run_instr(input logic [10:0] o, input logic z, input int fw, input int mw);
    bit ok;
    int c;
    op = o;
    zero = z;
    c = cls(o);
    wait_phase(FETCH, fw, ok);
    if (!ok) return;
    step(DECODE, rnd());
    case (c)
      1, 2: begin
        step(ADDR, rnd());
        wait_phase(c == 1 ? MEMRD : MEMWR, mw, ok);
        if (!ok) return;
        if (c == 1) step(LDWB, rnd());
      end
      3: begin step(REXEC, rnd()); step(RWB, rnd()); end
      4: step(CBZ, rnd());
      5: step(BR, rnd());
      default: begin
        ill_m = 1'b1;
        halt_and_reset();
        return;
      end
    endcase
    cnt_m++;
  endtask
  function automatic logic [10:0] rand_op();
    logic [10:0] o;
    case ($urandom_range(0, 11))
      0, 1: o = LDUR_OP;
      2, 3: o = STUR_OP;
      4: o = 11'b10001011000;
      5: o = 11'b11001011000;
      6: o = 11'b10001010000;
      7: o = 11'b10101010000;
      8, 9: o = {8'b10110100, 3'($urandom_range(0, 7))};
      10: o = {6'b000101, 5'($urandom_range(0, 31))};
      default: begin
        o = 11'($urandom_range(0, 2047));
        while (cls(o) != 0) o = 11'($urandom_range(0, 2047));
      end
    endcase
    return o;
  endfunction
  function automatic int rand_wait();
    return ($urandom_range(0, 15) == 0) ? 4 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
  initial begin
    @(negedge clk);
    do_reset();
    op = LDUR_OP;
    step(FETCH, 1'b1);
    step(DECODE, 1'b1);
    step(ADDR, 1'b1);
    step(MEMRD, 1'b0);
    do_reset();
    run_instr(LDUR_OP, 1'b0, 0, 0);
    run_instr(STUR_OP, 1'b0, 0, 3);
    run_instr(11'b10001011000, 1'b0, 0, 0);
    run_instr(11'b10110100101, 1'b1, 0, 0);
    run_instr(11'b10110100101, 1'b0, 0, 0);
    chk("count_after_directed", instr_count, 32'd5);
    run_instr(11'b11111111111, 1'b0, 0, 0);
    run_instr(LDUR_OP, 1'b0, 4, 0);
    run_instr(LDUR_OP, 1'b0, 3, 0);
    run_instr(STUR_OP, 1'b0, 1, 4);
    run_instr(LDUR_OP, 1'b0, 2, 4);
    run_instr(11'b00010100000, 1'b0, 2, 0);
    for (int n = 0; n < 300; n++) run_instr(rand_op(), rnd(), rand_wait(), rand_wait());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the LEGv8 subset: LDUR, STUR, R-format ADD/SUB/AND/ORR, CBZ and B.
- Sequences a shared-memory multi-cycle datapath (PC, IR, register file, ALU, ALUOut, MDR) through fetch, decode, execute, memory and writeback steps.
- A ready handshake stalls the FSM on the single instruction/data memory port.
- Also keeps a retired-instruction counter, a sticky illegal-opcode fault and a memory-timeout fault.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- TIMEOUT, 255, maximum cycles to wait for mem_ready in one memory state; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset
- op  in  11  IR[31:21], the opcode field of the instruction held in IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory accepted or completed the current access this cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  IR load enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  writeback select: 1 = MDR, 0 = ALUOut
- reg2loc  out  1  read-register-2 select: 1 = Rt, 0 = Rm
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = reg A
- alu_src_b  out  2  ALU B select: 00 = reg B, 01 = const 4, 10 = sign-extended D offset, 11 = sign-extended branch offset << 2
- alu_op  out  2  ALU operation: 00 = add, 01 = pass B, 10 = R-format funct decode
- pc_source  out  1  PC source: 0 = ALU result, 1 = ALUOut
- state  out  4  current state code, for debug
- instr_count  out  CNT_W  count of retired instructions
- illegal  out  1  sticky illegal-opcode fault
- mem_fault  out  1  sticky memory-timeout fault

Behaviour:
- State codes: FETCH=0, DECODE=1, ADDR=2, MEMRD=3, LDWB=4, MEMWR=5, REXEC=6, RWB=7, CBZ=8, BR=9, HALT=15.
- Reset: while rst_n=0 at a clock edge, state<=FETCH, instr_count<=0, illegal<=0, mem_fault<=0 and the wait counter<=0.
  - While rst_n is low, every strobe output (pc_write, ir_write, mem_read, mem_write, reg_write) is forced to 0.
  - All other outputs take their FETCH values while rst_n is low.
  - Reset mid-instruction aborts the instruction; no partial writeback.
- Outputs are decoded combinationally from state. Signals not listed for a state are 0.
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=0; ir_write=pc_write=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target to ALUOut). reg2loc=1 for STUR or CBZ, else 0.
  - DECODE dispatch, one cycle:
    - 11111000010 LDUR or 11111000000 STUR -> ADDR
    - 10001011000, 11001011000, 10001010000, 10101010000 -> REXEC
    - 10110100xxx -> CBZ
    - 000101xxxxx -> BR
    - anything else -> HALT with illegal<=1
  - ADDR: alu_src_a=1, alu_src_b=10, alu_op=00, reg2loc=1 for STUR. Go to MEMRD for LDUR, MEMWR for STUR.
  - MEMRD: i_or_d=1, mem_read=1. Wait for mem_ready, then go to LDWB.
  - LDWB: reg_write=1, mem_to_reg=1. Go to FETCH.
  - MEMWR: i_or_d=1, mem_write=1, reg2loc=1. Wait for mem_ready, then go to FETCH.
  - REXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to RWB.
  - RWB: reg_write=1, mem_to_reg=0. Go to FETCH.
  - CBZ: reg2loc=1, alu_src_b=00, alu_op=01, pc_source=1, pc_write=zero. Go to FETCH.
  - BR: pc_write=1, pc_source=1. Go to FETCH.
  - HALT: absorbing; all strobes 0. Leaves HALT only on reset.
- Requests are held stable until mem_ready; the memory must not see a request dropped mid-wait.
- op is sampled only in DECODE and ADDR; IR is stable there.
- instr_count increments by 1 on each transition into FETCH from LDWB, MEMWR, RWB, CBZ or BR. It wraps modulo 2^CNT_W.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD and MEMWR, and on each mem_ready.
  - Increments on each cycle spent in one of those states without mem_ready.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT with mem_ready still low: go to HALT, mem_fault<=1.
  - mem_ready in the same cycle as the TIMEOUT-th wait wins; no fault is raised.
- CBZ not taken (zero=0) still retires and counts.

Test Plan:
- Reset, then LDUR (op=11111000010) with mem_ready=1 every cycle -> state sequence 0,1,2,3,4,0; reg_write=mem_to_reg=1 only in LDWB; instr_count=1.
- STUR with mem_ready low for 3 cycles in MEMWR -> mem_write=1, i_or_d=1 held for 4 cycles; no reg_write; FETCH after the ready cycle; instr_count increments once.
- ADD 10001011000 then CBZ 10110100101 with zero=1, then CBZ with zero=0 -> R path 0,1,6,7,0; first CBZ pc_write=1 in CBZ state; second pc_write=0; instr_count=3.
- Illegal op 11111111111 -> HALT (15), illegal=1, all strobes 0 indefinitely; rst_n=0 for one cycle -> state=0, illegal=0, instr_count=0.
- TIMEOUT=4, mem_ready held low in FETCH -> after 4 waiting cycles state=15, mem_fault=1; repeat with mem_ready on the 4th cycle -> DECODE, no fault.
- rst_n asserted during MEMRD -> next state FETCH; no reg_write pulse ever issued for the aborted LDUR; instr_count=0.
